// File: rtl/rle_stream_encoder.sv
// Run-length encoder for classified pixel streams: turns each line into ordered
// (value, length, last) runs and queues them in a show-ahead FIFO with valid/ready output.
module rle_stream_encoder #(
    parameter int unsigned IMAGE_W    = 640,
    parameter int unsigned PIXEL_W    = 1,
    parameter int unsigned RUN_W      = 10,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [PIXEL_W-1:0]            pixel_in,
    input  logic                          pixel_valid,
    output logic [PIXEL_W-1:0]            run_value,
    output logic [RUN_W-1:0]              run_length,
    output logic                          run_last,
    output logic                          run_valid,
    input  logic                          run_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          line_done
);

    localparam int unsigned IDX_W = (IMAGE_W > 1) ? $clog2(IMAGE_W) : 1;
    localparam int unsigned AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LVL_W = AW + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IMAGE_W - 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = {RUN_W{1'b1}};
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    typedef struct packed {
        logic [PIXEL_W-1:0] value;
        logic [RUN_W-1:0]   length;
        logic               last;
    } run_t;

    logic [IDX_W-1:0]   r_pix_idx;
    logic [PIXEL_W-1:0] r_cur_val;
    logic [RUN_W-1:0]   r_cur_len;
    logic               r_have_run;
    logic               r_skid_valid;
    logic [PIXEL_W-1:0] r_skid_val;
    logic               r_line_done;
    logic               r_overflow;

    run_t               r_mem [FIFO_DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [LVL_W-1:0]   r_level;

    logic               w_end;
    logic               w_extend;
    logic               w_close;
    logic               w_push;
    run_t               w_push_run;
    logic               w_pop;
    logic               w_full;
    logic               w_wr;
    run_t               w_head;

    assign w_end    = (r_pix_idx == LAST_IDX);
    assign w_extend = pixel_valid && r_have_run && (pixel_in == r_cur_val) && (r_cur_len != RUN_MAX);
    assign w_close  = pixel_valid && r_have_run && !w_extend;

    // One push per edge; a pending skid run always goes first.
    always_comb begin
        w_push     = 1'b0;
        w_push_run = '0;
        if (r_skid_valid) begin
            w_push            = 1'b1;
            w_push_run.value  = r_skid_val;
            w_push_run.length = RUN_W'(1);
            w_push_run.last   = 1'b1;
        end else if (w_close) begin
            w_push            = 1'b1;
            w_push_run.value  = r_cur_val;
            w_push_run.length = r_cur_len;
            w_push_run.last   = 1'b0;
        end else if (pixel_valid && w_end) begin
            w_push          = 1'b1;
            w_push_run.last = 1'b1;
            if (w_extend) begin
                w_push_run.value  = r_cur_val;
                w_push_run.length = r_cur_len + RUN_W'(1);
            end else begin
                w_push_run.value  = pixel_in;
                w_push_run.length = RUN_W'(1);
            end
        end
    end

    assign w_pop  = (r_level != '0) && run_ready;
    assign w_full = (r_level == FULL_LVL);
    assign w_wr   = w_push && (!w_full || w_pop);

    // Run builder: pixel index, open run and the end-of-line skid entry.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pix_idx    <= '0;
            r_cur_val    <= '0;
            r_cur_len    <= '0;
            r_have_run   <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_val   <= '0;
            r_line_done  <= 1'b0;
        end else begin
            r_line_done  <= pixel_valid && w_end;
            r_skid_valid <= w_close && w_end;
            if (w_close && w_end) begin
                r_skid_val <= pixel_in;
            end
            if (pixel_valid) begin
                if (w_end) begin
                    r_pix_idx  <= '0;
                    r_have_run <= 1'b0;
                end else begin
                    r_pix_idx  <= r_pix_idx + IDX_W'(1);
                    r_have_run <= 1'b1;
                end
                if (w_extend) begin
                    r_cur_len <= r_cur_len + RUN_W'(1);
                end else begin
                    r_cur_val <= pixel_in;
                    r_cur_len <= RUN_W'(1);
                end
            end
        end
    end

    // FIFO control: pointers, level and sticky overflow on a dropped push.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push && !w_wr) begin
                r_overflow <= 1'b1;
            end
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_wr && !w_pop) begin
                r_level <= r_level + LVL_W'(1);
            end else if (!w_wr && w_pop) begin
                r_level <= r_level - LVL_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_wr && !RST) begin
            r_mem[r_wr_ptr] <= w_push_run;
        end
    end

    assign w_head     = r_mem[r_rd_ptr];
    assign run_valid  = (r_level != '0);
    assign run_value  = run_valid ? w_head.value  : '0;
    assign run_length = run_valid ? w_head.length : '0;
    assign run_last   = run_valid ? w_head.last   : 1'b0;
    assign fifo_level = r_level;
    assign overflow   = r_overflow;
    assign line_done  = r_line_done;

endmodule

// File: tb/tb_rle_stream_encoder.sv
// Directed self-checking bench for rle_stream_encoder: two instances (RUN_W=10 and RUN_W=2)
// share one 8-pixel-line stimulus stream; popped runs are logged and compared to hand-derived lists.
module tb_rle_stream_encoder;

    logic       clk;
    logic       rst;
    logic       pix;
    logic       pv;
    logic       rr;

    logic       a_value, a_last, a_valid, a_ovf, a_ld;
    logic [9:0] a_length;
    logic [2:0] a_level;
    logic       b_value, b_last, b_valid, b_ovf, b_ld;
    logic [1:0] b_length;
    logic [2:0] b_level;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int lda      = 0;
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    int          ca[$];

    rle_stream_encoder #(.IMAGE_W(8), .PIXEL_W(1), .RUN_W(10), .FIFO_DEPTH(4)) dut_a (
        .CLK(clk), .RST(rst), .pixel_in(pix), .pixel_valid(pv),
        .run_value(a_value), .run_length(a_length), .run_last(a_last), .run_valid(a_valid),
        .run_ready(rr), .fifo_level(a_level), .overflow(a_ovf), .line_done(a_ld)
    );

    rle_stream_encoder #(.IMAGE_W(8), .PIXEL_W(1), .RUN_W(2), .FIFO_DEPTH(4)) dut_b (
        .CLK(clk), .RST(rst), .pixel_in(pix), .pixel_valid(pv),
        .run_value(b_value), .run_length(b_length), .run_last(b_last), .run_valid(b_valid),
        .run_ready(rr), .fifo_level(b_level), .overflow(b_ovf), .line_done(b_ld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pk(input logic v, input int l, input logic last);
        logic [31:0] lv;
        lv = 32'(l);
        return {20'b0, v, lv[9:0], last};
    endfunction

    // Logs every pop (handshake seen at the edge) and line_done pulses.
    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            if (a_valid && rr) begin
                qa.push_back(pk(a_value, int'(a_length), a_last));
                ca.push_back(cyc);
            end
            if (b_valid && rr) begin
                qb.push_back(pk(b_value, int'(b_length), b_last));
            end
            if (a_ld) lda++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] qa_at(input int i);
        return (i < qa.size()) ? qa[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] qb_at(input int i);
        return (i < qb.size()) ? qb[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic clear_logs();
        qa.delete();
        qb.delete();
        ca.delete();
        lda = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pv = 1'b0;
        end
    endtask

    // p is written in stream order: bit 7 is the first pixel of the line.
    task automatic drive_line(input logic [7:0] p, input int gap_at);
        for (int i = 0; i < 8; i++) begin
            if (i == gap_at) begin
                @(negedge clk);
                pv = 1'b0;
            end
            @(negedge clk);
            pv  = 1'b1;
            pix = p[7-i];
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},  32'(a_valid),  32'd0);
        check({tag, "_level"},  32'(a_level),  32'd0);
        check({tag, "_ovf"},    32'(a_ovf),    32'd0);
        check({tag, "_ld"},     32'(a_ld),     32'd0);
        check({tag, "_head"},   pk(a_value, int'(a_length), a_last), 32'd0);
        check({tag, "_b_level"}, 32'(b_level), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] part;
        rst = 1'b1; pv = 1'b0; rr = 1'b1; pix = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst0");
        rst = 1'b0;

        // Basic line: 0,0,1,1,1,0,0,0
        clear_logs();
        drive_line(8'b00111000, 99);
        @(negedge clk);
        pv = 1'b0;
        check("t1_line_done", 32'(a_ld), 32'd1);
        idle(4);
        check("t1_cnt",  32'(qa.size()), 32'd3);
        check("t1_run0", qa_at(0), pk(1'b0, 2, 1'b0));
        check("t1_run1", qa_at(1), pk(1'b1, 3, 1'b0));
        check("t1_run2", qa_at(2), pk(1'b0, 3, 1'b1));
        check("t1_ld_cnt", 32'(lda), 32'd1);

        // All ones with a pixel_valid gap; B saturates at length 3
        clear_logs();
        drive_line(8'hFF, 3);
        idle(4);
        check("t2_a_cnt",  32'(qa.size()), 32'd1);
        check("t2_a_run0", qa_at(0), pk(1'b1, 8, 1'b1));
        check("t2_b_cnt",  32'(qb.size()), 32'd3);
        check("t2_b_run0", qb_at(0), pk(1'b1, 3, 1'b0));
        check("t2_b_run1", qb_at(1), pk(1'b1, 3, 1'b0));
        check("t2_b_run2", qb_at(2), pk(1'b1, 2, 1'b1));

        // All zeros
        clear_logs();
        drive_line(8'h00, 99);
        idle(4);
        check("t3_a_run0", qa_at(0), pk(1'b0, 8, 1'b1));
        check("t3_b_cnt",  32'(qb.size()), 32'd3);
        check("t3_b_run0", qb_at(0), pk(1'b0, 3, 1'b0));
        check("t3_b_run1", qb_at(1), pk(1'b0, 3, 1'b0));
        check("t3_b_run2", qb_at(2), pk(1'b0, 2, 1'b1));

        // Final pixel closes a run and is a run of 1: skid, then next line back to back
        clear_logs();
        drive_line(8'b00000001, 99);
        drive_line(8'b11000000, 99);
        idle(4);
        check("t4_cnt",  32'(qa.size()), 32'd4);
        check("t4_run0", qa_at(0), pk(1'b0, 7, 1'b0));
        check("t4_run1", qa_at(1), pk(1'b1, 1, 1'b1));
        check("t4_run2", qa_at(2), pk(1'b1, 2, 1'b0));
        check("t4_run3", qa_at(3), pk(1'b0, 6, 1'b1));
        check("t4_skid_gap", (ca.size() >= 2) ? 32'(ca[1] - ca[0]) : 32'hFFFF_FFFF, 32'd1);
        check("t4_ld_cnt", 32'(lda), 32'd2);

        // Stalled consumer: 8 runs into a 4-deep FIFO
        clear_logs();
        rr = 1'b0;
        drive_line(8'b01010101, 99);
        idle(4);
        check("t5_level", 32'(a_level), 32'd4);
        check("t5_ovf",   32'(a_ovf),   32'd1);
        check("t5_valid", 32'(a_valid), 32'd1);
        check("t5_head",  pk(a_value, int'(a_length), a_last), pk(1'b0, 1, 1'b0));
        check("t5_nopop", 32'(qa.size()), 32'd0);
        rr = 1'b1;
        idle(6);
        check("t5_cnt",  32'(qa.size()), 32'd4);
        check("t5_run0", qa_at(0), pk(1'b0, 1, 1'b0));
        check("t5_run1", qa_at(1), pk(1'b1, 1, 1'b0));
        check("t5_run2", qa_at(2), pk(1'b0, 1, 1'b0));
        check("t5_run3", qa_at(3), pk(1'b1, 1, 1'b0));
        check("t5_drained_valid", 32'(a_valid), 32'd0);
        check("t5_drained_level", 32'(a_level), 32'd0);
        check("t5_ovf_sticky",    32'(a_ovf),   32'd1);

        // Reset mid-line at pix_idx 5 with two runs queued
        clear_logs();
        rr   = 1'b0;
        part = 5'b00110;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            pv  = 1'b1;
            pix = part[4-i];
        end
        @(negedge clk);
        pv = 1'b0;
        check("t6_pre_level", 32'(a_level), 32'd2);
        rst = 1'b1; pv = 1'b1; pix = 1'b1; rr = 1'b1;
        @(negedge clk);
        check_reset_outputs("t6_rst");
        rst = 1'b0; pv = 1'b0;
        clear_logs();
        drive_line(8'b00111000, 99);
        idle(4);
        check("t6_cnt",  32'(qa.size()), 32'd3);
        check("t6_run0", qa_at(0), pk(1'b0, 2, 1'b0));
        check("t6_run1", qa_at(1), pk(1'b1, 3, 1'b0));
        check("t6_run2", qa_at(2), pk(1'b0, 3, 1'b1));
        check("t6_ld_cnt", 32'(lda), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
